seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with frame-latched data,
// leading-zero blanking on the tens digit, a fixed ones-digit decimal point and an alarm blink.
module seg_scan_driver #(
   parameter int SCAN_CNT_MAX = 50000,
   parameter int BLINK_TICKS  = 250
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [23:0] dis_data,
   input  logic        en,
   output logic [5:0]  sel,
   output logic [7:0]  seg
);

   localparam int CNT_W = (SCAN_CNT_MAX > 1) ? $clog2(SCAN_CNT_MAX) : 1;
   localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT_MAX - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

   typedef enum logic {
      PHASE_ON,
      PHASE_OFF
   } phase_t;

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [23:0]      shadow, shadow_nxt;
   logic [BLK_W-1:0] blink_cnt, blink_nxt;
   phase_t           phase, phase_nxt;
   logic [5:0]       sel_nxt;
   logic [7:0]       seg_nxt;
   logic             digit_tick;
   logic [3:0]       code;
   logic [6:0]       glyph;
   logic             display_on;

   // Active-low {g,f,e,d,c,b,a}; B is the minus sign, every other non-digit is blank.
   function automatic logic [6:0] decode(input logic [3:0] c);
      case (c)
         4'h0:    decode = 7'h40;
         4'h1:    decode = 7'h79;
         4'h2:    decode = 7'h24;
         4'h3:    decode = 7'h30;
         4'h4:    decode = 7'h19;
         4'h5:    decode = 7'h12;
         4'h6:    decode = 7'h02;
         4'h7:    decode = 7'h78;
         4'h8:    decode = 7'h00;
         4'h9:    decode = 7'h10;
         4'hB:    decode = 7'h3F;
         default: decode = 7'h7F;
      endcase
   endfunction

   always_comb begin
      digit_tick = (cnt == CNT_LAST);
      cnt_nxt    = digit_tick ? '0 : cnt + CNT_W'(1);
      idx_nxt    = idx;
      shadow_nxt = shadow;
      blink_nxt  = blink_cnt;
      phase_nxt  = phase;

      if (digit_tick) begin
         idx_nxt = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
         if (idx == 3'd0)
            shadow_nxt = dis_data;
      end

      // Blink runs only while the alarm is up; dropping en snaps straight back to lit.
      if (!en) begin
         blink_nxt = '0;
         phase_nxt = PHASE_ON;
      end else if (digit_tick) begin
         if (blink_cnt == BLK_LAST) begin
            blink_nxt = '0;
            phase_nxt = (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
         end else begin
            blink_nxt = blink_cnt + BLK_W'(1);
         end
      end

      case (idx)
         3'd0:    code = shadow[3:0];
         3'd1:    code = shadow[7:4];
         3'd2:    code = shadow[11:8];
         3'd3:    code = shadow[15:12];
         3'd4:    code = shadow[19:16];
         3'd5:    code = shadow[23:20];
         default: code = 4'hF;
      endcase

      glyph = decode(code);
      if (idx == 3'd4 && code == 4'h0)
         glyph = 7'h7F;

      // en is folded in here so a dropped alarm lights the very next output update.
      display_on = !en || (phase == PHASE_ON);
      sel_nxt    = 6'h3F;
      seg_nxt    = 8'hFF;
      if (display_on) begin
         sel_nxt = ~(6'd1 << idx);
         seg_nxt = {(idx != 3'd3), glyph};
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt       <= '0;
         idx       <= 3'd5;
         shadow    <= 24'hA00000;
         blink_cnt <= '0;
         phase     <= PHASE_ON;
         sel       <= 6'h3F;
         seg       <= 8'hFF;
      end else begin
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shadow    <= shadow_nxt;
         blink_cnt <= blink_nxt;
         phase     <= phase_nxt;
         sel       <= sel_nxt;
         seg       <= seg_nxt;
      end
   end

endmodule
